alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Registered decode/issue stage that drives the RV32I ALU operand and select interface. Accepts one instruction per cycle with its register-file operands and PC, decodes opcode/funct3/funct7 into the 4-bit ALU select code, and forms operands A/B. It holds the result in a single output register with valid/ready handshake, flush and illegal-instruction flagging. It sits between register-file read and the execute stage.

## Interface
- N, 32, datapath width (instruction fixed at 32 bits)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  kill held and incoming instruction
- in_valid  in  1  instruction/operands valid
- in_ready  out  1  stage accepts this cycle
- in_instr  in  32  instruction word
- in_pc  in  N  instruction PC
- in_rs1_val  in  N  rs1 read data
- in_rs2_val  in  N  rs2 read data
- out_valid  out  1  issue register holds an instruction
- out_ready  in  1  execute stage consumes
- out_sel  out  4  ALU select code
- out_a  out  N  ALU operand A
- out_b  out  N  ALU operand B
- out_rd  out  5  destination register
- out_we  out  1  register write enable
- out_illegal  out  1  undecodable instruction

## Operation
- Select codes: AND 0, OR 1, XOR 2, ADD 3, SUB 4, SLT 5, SLTU 6, SLLI 7, SRLI 8, SRAI 9, SLL 10, SRL 11, SRA 12.
- OP (0110011): A=rs1, B=rs2. funct3 0: funct7 0x00 ADD, 0x20 SUB; 1 SLL; 2 SLT; 3 SLTU; 4 XOR; 5: 0x00 SRL, 0x20 SRA; 6 OR; 7 AND. Any funct7 other than the listed values → illegal. we=1.
- OP-IMM (0010011): A=rs1, B=sign-extended I-imm. addi ADD, slti SLT, sltiu SLTU, xori XOR, ori OR, andi AND. slli (funct7 0x00) SLLI; srli (0x00) SRLI; srai (0x20) SRAI. For shifts, B={27'b0, shamt}. Other funct7 → illegal. we=1.
- LOAD (0000011): ADD, A=rs1, B=I-imm, we=1. STORE (0100011): ADD, A=rs1, B=S-imm, we=0.
- BRANCH (1100011): A=rs1, B=rs2, we=0. beq/bne SUB; blt/bge SLT; bltu/bgeu SLTU. funct3 2,3 → illegal.
- LUI (0110111): ADD, A=0, B=U-imm, we=1. AUIPC (0010111): ADD, A=pc, B=U-imm, we=1.
- Illegal/unknown opcode: illegal=1, sel=0, a=0, b=0, we=0, rd=instr[11:7]. The stage still issues it with out_valid=1.
- rd=instr[11:7] for all decodes. we is forced 0 when rd=0.

## Timing
- Latency 1 cycle: a transfer accepted at edge k appears at the outputs after edge k.
- in_ready = !flush && (!out_valid || out_ready). This is a combinational path from out_valid/out_ready/flush.
- Transfer occurs on in_valid && in_ready. Output is consumed on out_valid && out_ready.
- Full and consumed while a new instruction is offered: the register is replaced in the same edge, giving back-to-back throughput of 1/cycle.
- Consumed with no new input: out_valid→0. Payload is held unchanged while out_valid && !out_ready.
- flush: out_valid→0 at next edge. The incoming instruction is not accepted (in_ready=0). Flush dominates all other events.
- Reset (any time, including mid-stall): out_valid, out_sel, out_a, out_b, out_rd, out_we, out_illegal all 0 immediately. in_ready=1 once rst deasserts with flush=0.
- Payload registers load only on a transfer. out_illegal and out_we are registered with the payload.

## Structure
- Shared package alu_pkg holds the select-code localparams (ALU_AND…ALU_SRA) and opcode constants (OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC), for reuse by the ALU and hazard logic.
- One combinational sub-module, alu_decode, maps instr/pc/rs1/rs2 to sel/a/b/rd/we/illegal. The top level holds the valid/ready register.

## Test plan
- Reset, then in_instr=0x40B50533 (sub x10,x10,x11), rs1=7, rs2=3, out_ready=1 → next cycle out_valid=1, sel=4, a=7, b=3, rd=10, we=1, illegal=0.
- 0xFFF00093 (addi x1,x0,-1) → sel=3, b=0xFFFFFFFF, rd=1, we=1. Then 0x40335293 (srai x5,x6,3) → sel=9, b=0x00000003.
- 0x12345197 (auipc x3) with pc=0x100 → sel=3, a=0x100, b=0x12345000. A bltu gives sel=6, we=0. Opcode 0x7F gives illegal=1, we=0.
- Stall: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs frozen. Raise out_ready → one output consumed per cycle, no instruction lost or duplicated over a 10-instruction stream.
- Flush while stalled with in_valid=1 → out_valid=0 next cycle, incoming instruction dropped. rst asserted mid-stall → all outputs 0 asynchronously.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared RV32I ALU select codes and base opcodes, used by the issue stage,
// the ALU and the hazard logic.
package alu_pkg;
   localparam logic [3:0] ALU_AND  = 4'd0;
   localparam logic [3:0] ALU_OR   = 4'd1;
   localparam logic [3:0] ALU_XOR  = 4'd2;
   localparam logic [3:0] ALU_ADD  = 4'd3;
   localparam logic [3:0] ALU_SUB  = 4'd4;
   localparam logic [3:0] ALU_SLT  = 4'd5;
   localparam logic [3:0] ALU_SLTU = 4'd6;
   localparam logic [3:0] ALU_SLLI = 4'd7;
   localparam logic [3:0] ALU_SRLI = 4'd8;
   localparam logic [3:0] ALU_SRAI = 4'd9;
   localparam logic [3:0] ALU_SLL  = 4'd10;
   localparam logic [3:0] ALU_SRL  = 4'd11;
   localparam logic [3:0] ALU_SRA  = 4'd12;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_BASE = 7'h00;
   localparam logic [6:0] F7_ALT  = 7'h20;
endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I decode: instruction, PC and register operands to
// ALU select, operands, destination and write enable.
module alu_decode
   import alu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [31:0]       instr,
   input  logic [DATA_W-1:0] pc,
   input  logic [DATA_W-1:0] rs1_val,
   input  logic [DATA_W-1:0] rs2_val,
   output logic [3:0]        sel,
   output logic [DATA_W-1:0] a,
   output logic [DATA_W-1:0] b,
   output logic [4:0]        rd,
   output logic              we,
   output logic              illegal
);
   logic [6:0]        opc;
   logic [2:0]        funct3;
   logic [6:0]        funct7;
   logic signed [11:0] imm_i_s;
   logic signed [11:0] imm_s_s;
   logic signed [31:0] imm_u_s;
   logic [DATA_W-1:0] imm_i;
   logic [DATA_W-1:0] imm_s;
   logic [DATA_W-1:0] imm_u;
   logic [DATA_W-1:0] shamt;
   logic              wr;
   logic              bad;

   assign opc     = instr[6:0];
   assign funct3  = instr[14:12];
   assign funct7  = instr[31:25];
   assign imm_i_s = instr[31:20];
   assign imm_s_s = {instr[31:25], instr[11:7]};
   assign imm_u_s = {instr[31:12], 12'h000};
   assign imm_i   = DATA_W'(imm_i_s);
   assign imm_s   = DATA_W'(imm_s_s);
   assign imm_u   = DATA_W'(imm_u_s);
   assign shamt   = DATA_W'(instr[24:20]);

   always_comb begin
      sel = ALU_ADD;
      a   = '0;
      b   = '0;
      wr  = 1'b0;
      bad = 1'b0;
      case (opc)
         OPC_OP: begin
            a  = rs1_val;
            b  = rs2_val;
            wr = 1'b1;
            case (funct3)
               3'd0: begin
                  if (funct7 == F7_BASE)     sel = ALU_ADD;
                  else if (funct7 == F7_ALT) sel = ALU_SUB;
                  else                       bad = 1'b1;
               end
               3'd5: begin
                  if (funct7 == F7_BASE)     sel = ALU_SRL;
                  else if (funct7 == F7_ALT) sel = ALU_SRA;
                  else                       bad = 1'b1;
               end
               default: begin
                  bad = (funct7 != F7_BASE);
                  case (funct3)
                     3'd1:    sel = ALU_SLL;
                     3'd2:    sel = ALU_SLT;
                     3'd3:    sel = ALU_SLTU;
                     3'd4:    sel = ALU_XOR;
                     3'd6:    sel = ALU_OR;
                     default: sel = ALU_AND;
                  endcase
               end
            endcase
         end
         OPC_OPIMM: begin
            a  = rs1_val;
            b  = imm_i;
            wr = 1'b1;
            case (funct3)
               3'd0: sel = ALU_ADD;
               3'd2: sel = ALU_SLT;
               3'd3: sel = ALU_SLTU;
               3'd4: sel = ALU_XOR;
               3'd6: sel = ALU_OR;
               3'd7: sel = ALU_AND;
               3'd1: begin
                  sel = ALU_SLLI;
                  b   = shamt;
                  bad = (funct7 != F7_BASE);
               end
               default: begin
                  b = shamt;
                  if (funct7 == F7_BASE)     sel = ALU_SRLI;
                  else if (funct7 == F7_ALT) sel = ALU_SRAI;
                  else                       bad = 1'b1;
               end
            endcase
         end
         OPC_LOAD: begin
            a  = rs1_val;
            b  = imm_i;
            wr = 1'b1;
         end
         OPC_STORE: begin
            a = rs1_val;
            b = imm_s;
         end
         OPC_BRANCH: begin
            a = rs1_val;
            b = rs2_val;
            case (funct3)
               3'd0, 3'd1: sel = ALU_SUB;
               3'd4, 3'd5: sel = ALU_SLT;
               3'd6, 3'd7: sel = ALU_SLTU;
               default:    bad = 1'b1;
            endcase
         end
         OPC_LUI: begin
            b  = imm_u;
            wr = 1'b1;
         end
         OPC_AUIPC: begin
            a  = pc;
            b  = imm_u;
            wr = 1'b1;
         end
         default: bad = 1'b1;
      endcase
      // Undecodable instructions issue as an inert AND of zeros.
      if (bad) begin
         sel = ALU_AND;
         a   = '0;
         b   = '0;
         wr  = 1'b0;
      end
   end

   assign rd      = instr[11:7];
   assign we      = wr && (instr[11:7] != 5'd0);
   assign illegal = bad;
endmodule

// File: rtl/alu_issue_stage.sv
// Registered issue stage: decodes one instruction per cycle into the ALU
// operand/select interface behind a single valid/ready output register.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [DATA_W-1:0] in_rs1_val,
   input  logic [DATA_W-1:0] in_rs2_val,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        out_sel,
   output logic [DATA_W-1:0] out_a,
   output logic [DATA_W-1:0] out_b,
   output logic [4:0]        out_rd,
   output logic              out_we,
   output logic              out_illegal
);
   logic [3:0]        sel_p0;
   logic [DATA_W-1:0] a_p0;
   logic [DATA_W-1:0] b_p0;
   logic [4:0]        rd_p0;
   logic              we_p0;
   logic              ill_p0;

   logic              vld_p1;
   logic [3:0]        sel_p1;
   logic [DATA_W-1:0] a_p1;
   logic [DATA_W-1:0] b_p1;
   logic [4:0]        rd_p1;
   logic              we_p1;
   logic              ill_p1;
   logic              xfer;

   alu_decode #(.DATA_W(DATA_W)) u_decode (
      .instr   (in_instr),
      .pc      (in_pc),
      .rs1_val (in_rs1_val),
      .rs2_val (in_rs2_val),
      .sel     (sel_p0),
      .a       (a_p0),
      .b       (b_p0),
      .rd      (rd_p0),
      .we      (we_p0),
      .illegal (ill_p0)
   );

   assign in_ready = !flush && (!vld_p1 || out_ready);
   assign xfer     = in_valid && in_ready;

   // p0 -> p1: issue register; flush wins over both load and consume
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1 <= 1'b0;
         sel_p1 <= '0;
         a_p1   <= '0;
         b_p1   <= '0;
         rd_p1  <= '0;
         we_p1  <= 1'b0;
         ill_p1 <= 1'b0;
      end else if (flush) begin
         vld_p1 <= 1'b0;
      end else if (xfer) begin
         vld_p1 <= 1'b1;
         sel_p1 <= sel_p0;
         a_p1   <= a_p0;
         b_p1   <= b_p0;
         rd_p1  <= rd_p0;
         we_p1  <= we_p0;
         ill_p1 <= ill_p0;
      end else if (out_ready) begin
         vld_p1 <= 1'b0;
      end
   end

   assign out_valid   = vld_p1;
   assign out_sel     = sel_p1;
   assign out_a       = a_p1;
   assign out_b       = b_p1;
   assign out_rd      = rd_p1;
   assign out_we      = we_p1;
   assign out_illegal = ill_p1;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized and directed bench for alu_issue_stage against a behavioural
// instruction-level reference model.
module tb_alu_issue_stage;
   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic [31:0] in_rs1_val;
   logic [31:0] in_rs2_val;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_sel;
   logic [31:0] out_a;
   logic [31:0] out_b;
   logic [4:0]  out_rd;
   logic        out_we;
   logic        out_illegal;

   alu_issue_stage #(.DATA_W(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .in_pc       (in_pc),
      .in_rs1_val  (in_rs1_val),
      .in_rs2_val  (in_rs2_val),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_sel     (out_sel),
      .out_a       (out_a),
      .out_b       (out_b),
      .out_rd      (out_rd),
      .out_we      (out_we),
      .out_illegal (out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  sel;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        we;
      logic        ill;
   } exp_t;

   // Mnemonic -> select code tables indexed by funct3; -1 means undecodable.
   int op_tab  [8] = '{3, 10, 5, 6, 2, 11, 1, 0};
   int opi_tab [8] = '{3, 7, 5, 6, 2, 8, 1, 0};
   int br_tab  [8] = '{4, 4, -1, -1, 5, 5, 6, 6};
   logic [6:0] opc_pick [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h7F, 7'h0B};

   int          n_tests = 0;
   int          n_fail  = 0;
   logic        exp_vld = 1'b0;
   exp_t        exp_q;
   logic        last_xfer;
   logic [31:0] obs_q [$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                       input logic [31:0] rs1, input logic [31:0] rs2);
      exp_t e;
      int   s;
      logic [2:0] f3;
      logic [6:0] f7;
      logic [31:0] immi;
      logic [31:0] imms;
      logic [31:0] immu;
      f3   = ins[14:12];
      f7   = ins[31:25];
      immi = {{20{ins[31]}}, ins[31:20]};
      imms = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      immu = {ins[31:12], 12'h000};
      e    = '0;
      e.rd = ins[11:7];
      s    = -1;
      case (ins[6:0])
         7'h33: begin
            e.a = rs1; e.b = rs2; e.we = 1'b1;
            if (f7 == 7'h00)                   s = op_tab[f3];
            else if (f7 == 7'h20 && f3 == 3'd0) s = 4;
            else if (f7 == 7'h20 && f3 == 3'd5) s = 12;
         end
         7'h13: begin
            e.a = rs1; e.b = immi; e.we = 1'b1;
            if (f3 == 3'd1 || f3 == 3'd5) begin
               e.b = {27'd0, ins[24:20]};
               if (f7 == 7'h00)                   s = opi_tab[f3];
               else if (f7 == 7'h20 && f3 == 3'd5) s = 9;
            end else begin
               s = opi_tab[f3];
            end
         end
         7'h03: begin s = 3; e.a = rs1; e.b = immi; e.we = 1'b1; end
         7'h23: begin s = 3; e.a = rs1; e.b = imms; end
         7'h63: begin e.a = rs1; e.b = rs2; s = br_tab[f3]; end
         7'h37: begin s = 3; e.b = immu; e.we = 1'b1; end
         7'h17: begin s = 3; e.a = pc; e.b = immu; e.we = 1'b1; end
         default: s = -1;
      endcase
      if (s < 0) begin
         e.sel = 4'd0; e.a = '0; e.b = '0; e.we = 1'b0; e.ill = 1'b1;
      end else begin
         e.sel = 4'(s);
      end
      if (e.rd == 5'd0) e.we = 1'b0;
      return e;
   endfunction

   // One clock of stimulus: drive after negedge, check, then advance the model.
   task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic ordy, input logic fl);
      logic exp_rdy;
      in_valid   = v;
      in_instr   = ins;
      in_pc      = pc;
      in_rs1_val = rs1;
      in_rs2_val = rs2;
      out_ready  = ordy;
      flush      = fl;
      #1;
      exp_rdy = !fl && (!exp_vld || ordy);
      check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
      check_eq("out_valid", 32'(out_valid), 32'(exp_vld));
      if (exp_vld) begin
         check_eq("sel", 32'(out_sel), 32'(exp_q.sel));
         check_eq("a", out_a, exp_q.a);
         check_eq("b", out_b, exp_q.b);
         check_eq("rd", 32'(out_rd), 32'(exp_q.rd));
         check_eq("we", 32'(out_we), 32'(exp_q.we));
         check_eq("illegal", 32'(out_illegal), 32'(exp_q.ill));
      end
      if (out_valid && ordy && !fl) obs_q.push_back(out_a);
      last_xfer = v && exp_rdy;
      @(posedge clk);
      if (fl)             exp_vld = 1'b0;
      else if (last_xfer) begin exp_vld = 1'b1; exp_q = ref_decode(ins, pc, rs1, rs2); end
      else if (ordy)      exp_vld = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
      check_eq({tag, "_sel"}, 32'(out_sel), 32'd0);
      check_eq({tag, "_a"}, out_a, 32'd0);
      check_eq({tag, "_b"}, out_b, 32'd0);
      check_eq({tag, "_rd"}, 32'(out_rd), 32'd0);
      check_eq({tag, "_we"}, 32'(out_we), 32'd0);
      check_eq({tag, "_illegal"}, 32'(out_illegal), 32'd0);
   endtask

   initial begin
      logic [31:0] ins;
      logic [31:0] held_a;
      int          idx;
      int          budget;

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = '0; in_pc = '0; in_rs1_val = '0; in_rs2_val = '0;
      last_xfer = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_all_zero("reset");
      check_eq("reset_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      exp_vld = 1'b0;

      // Directed decode cases
      cycle(1'b1, 32'h40B50533, 32'h0, 32'd7, 32'd3, 1'b1, 1'b0);
      check_eq("sub_valid", 32'(out_valid), 32'd1);
      check_eq("sub_sel", 32'(out_sel), 32'd4);
      check_eq("sub_a", out_a, 32'd7);
      check_eq("sub_b", out_b, 32'd3);
      check_eq("sub_rd", 32'(out_rd), 32'd10);
      check_eq("sub_we", 32'(out_we), 32'd1);
      check_eq("sub_ill", 32'(out_illegal), 32'd0);
      cycle(1'b1, 32'hFFF00093, 32'h0, 32'h55, 32'h0, 1'b1, 1'b0);
      check_eq("addi_sel", 32'(out_sel), 32'd3);
      check_eq("addi_b", out_b, 32'hFFFFFFFF);
      check_eq("addi_rd", 32'(out_rd), 32'd1);
      check_eq("addi_we", 32'(out_we), 32'd1);
      cycle(1'b1, 32'h40335293, 32'h0, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0);
      check_eq("srai_sel", 32'(out_sel), 32'd9);
      check_eq("srai_b", out_b, 32'h00000003);
      cycle(1'b1, 32'h12345197, 32'h100, 32'h0, 32'h0, 1'b1, 1'b0);
      check_eq("auipc_sel", 32'(out_sel), 32'd3);
      check_eq("auipc_a", out_a, 32'h100);
      check_eq("auipc_b", out_b, 32'h12345000);
      cycle(1'b1, 32'h0020E063, 32'h0, 32'd5, 32'd6, 1'b1, 1'b0);
      check_eq("bltu_sel", 32'(out_sel), 32'd6);
      check_eq("bltu_we", 32'(out_we), 32'd0);
      cycle(1'b1, 32'h0000057F, 32'h0, 32'd9, 32'd9, 1'b1, 1'b0);
      check_eq("badopc_ill", 32'(out_illegal), 32'd1);
      check_eq("badopc_we", 32'(out_we), 32'd0);
      check_eq("badopc_sel", 32'(out_sel), 32'd0);
      check_eq("badopc_rd", 32'(out_rd), 32'd10);

      // Stall: held instruction must freeze while new ones wait
      repeat (3) cycle(1'b1, 32'h002082B3, 32'h0, 32'd11, 32'd22, 1'b0, 1'b0);
      check_eq("stall_ill_held", 32'(out_illegal), 32'd1);
      check_eq("stall_in_ready", 32'(in_ready), 32'd0);
      cycle(1'b1, 32'h002082B3, 32'h0, 32'd11, 32'd22, 1'b1, 1'b0);
      check_eq("after_stall_a", out_a, 32'd11);

      // Flush while stalled with a new instruction offered
      cycle(1'b1, 32'h00308093, 32'h0, 32'd40, 32'd0, 1'b0, 1'b0);
      held_a = out_a;
      cycle(1'b1, 32'h00408093, 32'h0, 32'd41, 32'd0, 1'b0, 1'b1);
      check_eq("flush_valid", 32'(out_valid), 32'd0);
      check_eq("flush_payload_kept", out_a, held_a);
      cycle(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

      // 10-instruction stream under random back-pressure
      obs_q.delete();
      idx = 0;
      budget = 200;
      while ((idx < 10 || exp_vld) && budget > 0) begin
         cycle(idx < 10, 32'h002082B3, 32'h0, 32'd1000 + 32'(idx), 32'd1,
               1'($urandom_range(0, 1)), 1'b0);
         if (last_xfer) idx++;
         budget--;
      end
      check_eq("stream_budget", 32'(budget > 0), 32'd1);
      check_eq("stream_count", 32'(obs_q.size()), 32'd10);
      for (int i = 0; i < 10 && i < obs_q.size(); i++)
         check_eq("stream_order", obs_q[i], 32'd1000 + 32'(i));

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         ins = $urandom;
         ins[6:0] = opc_pick[$urandom_range(0, 8)];
         if ($urandom_range(0, 3) != 0) ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
         cycle($urandom_range(0, 3) != 0, ins, $urandom, $urandom, $urandom,
               $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      end

      // Reset asserted mid-stall clears outputs without a clock edge
      cycle(1'b1, 32'hFFF00093, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
      cycle(1'b1, 32'h40335293, 32'h0, 32'h7, 32'h0, 1'b0, 1'b0);
      in_valid = 1'b1;
      out_ready = 1'b0;
      flush = 1'b0;
      #3 rst = 1'b1;
      #1;
      check_all_zero("async_rst");
      check_eq("async_rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      exp_vld = 1'b0;
      cycle(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
